ram_fifo_ctrl: RTL and testbench

Controller that sequences a dualportram instance (1-cycle registered read, rdEn-gated dout hold) as a first-word-fall-through FIFO. Provides valid/ready push and pop handshakes. Generates all RAM write and read controls and circular pointers. RAM dout is used directly as the pop data, so streaming runs at one word per cycle with no output bubble.

---
 rtl/ram_fifo_ctrl_if.sv | 30 +++
 rtl/ram_fifo_ctrl.sv | 85 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Push and pop stream handshakes of the RAM-backed FIFO controller.
// The slave modport is the controller side; master is the producer/consumer side.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  inValid;
  logic                  inReady;
  logic [DATA_WIDTH-1:0] inData;
  logic                  outValid;
  logic                  outReady;
  logic [DATA_WIDTH-1:0] outData;

  modport slave (
    input  inValid,
    input  inData,
    input  outReady,
    output inReady,
    output outValid,
    output outData
  );

  modport master (
    output inValid,
    output inData,
    output outReady,
    input  inReady,
    input  outValid,
    input  outData
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM with a
// 1-cycle registered, rdEn-gated read port; the RAM dout register is the output stage.
module ram_fifo_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned AFULL_LEVEL   = 2 ** ADDRESS_WIDTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  ram_fifo_ctrl_if.slave           bus,
  output logic                     ramWrEn,
  output logic [ADDRESS_WIDTH-1:0] ramWrAddr,
  output logic [DATA_WIDTH-1:0]    ramDin,
  output logic                     ramRdEn,
  output logic [ADDRESS_WIDTH-1:0] ramRdAddr,
  input  logic [DATA_WIDTH-1:0]    ramDout,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     almostFull,
  output logic                     empty
);

  localparam int unsigned            DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] CountFull = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH:0]   ram_count_q, ram_count_d;
  logic                     out_valid_q, out_valid_d;

  logic clear;
  logic push;
  logic pop;
  logic issue;

  // Handshakes are masked while clearing so the RAM sees no traffic in that cycle.
  always_comb begin
    clear = !rst || flush;
    push  = bus.inValid && bus.inReady && !clear;
    pop   = out_valid_q && bus.outReady;
    issue = (ram_count_q != '0) && (!out_valid_q || bus.outReady) && !clear;
  end

  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + ADDRESS_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + ADDRESS_WIDTH'(1) : rd_ptr_q;
    out_valid_d = issue ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    ram_count_d = ram_count_q;
    case ({push, issue})
      2'b10:   ram_count_d = ram_count_q + (ADDRESS_WIDTH + 1)'(1);
      2'b01:   ram_count_d = ram_count_q - (ADDRESS_WIDTH + 1)'(1);
      default: ram_count_d = ram_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // inReady looks only at the RAM occupancy, never at outReady.
  assign bus.inReady  = (ram_count_q != CountFull);
  assign bus.outValid = out_valid_q;
  assign bus.outData  = ramDout;

  assign ramWrEn   = push;
  assign ramWrAddr = wr_ptr_q;
  assign ramDin    = bus.inData;
  assign ramRdEn   = issue;
  assign ramRdAddr = rd_ptr_q;

  assign level      = ram_count_q + (ADDRESS_WIDTH + 1)'(out_valid_q);
  assign almostFull = 32'(level) >= AFULL_LEVEL;
  assign empty      = (level == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM plus a queue-based model of
// RAM contents, output stage and push order.
module tb_ram_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ramWrEn;
  logic [AW-1:0] ramWrAddr;
  logic [DW-1:0] ramDin;
  logic          ramRdEn;
  logic [AW-1:0] ramRdAddr;
  logic [DW-1:0] ramDout;
  logic [AW:0]   level;
  logic          almostFull;
  logic          empty;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ram_fifo_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .AFULL_LEVEL  (AFULL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .ramWrEn   (ramWrEn),
    .ramWrAddr (ramWrAddr),
    .ramDin    (ramDin),
    .ramRdEn   (ramRdEn),
    .ramRdAddr (ramRdAddr),
    .ramDout   (ramDout),
    .level     (level),
    .almostFull(almostFull),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: registered read, dout holds when rdEn is low.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ramWrEn) mem[ramWrAddr] <= ramDin;
    if (ramRdEn) ramDout <= mem[ramRdAddr];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic [DW-1:0] ram_q[$];
  logic [DW-1:0] sb[$];
  bit            hv;
  logic [DW-1:0] hd;
  int            wr_cnt;
  int            rd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ram_q.delete();
    sb.delete();
    hv     = 1'b0;
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one edge.
  task automatic tick();
    bit            clr, m_inready, m_push, m_issue, m_pop;
    int            lvl;
    logic [DW-1:0] pdata;
    #1;
    clr       = (rst !== 1'b1) || (flush === 1'b1);
    m_inready = (ram_q.size() != DEPTH);
    m_push    = (bus.inValid === 1'b1) && m_inready && !clr;
    m_issue   = (ram_q.size() != 0) && (!hv || bus.outReady === 1'b1) && !clr;
    m_pop     = hv && (bus.outReady === 1'b1) && !clr;
    lvl       = ram_q.size() + int'(hv);
    pdata     = bus.inData;
    chk("inReady", 32'(bus.inReady), 32'(m_inready));
    chk("outValid", 32'(bus.outValid), 32'(hv));
    if (hv) chk("outData", 32'(bus.outData), 32'(hd));
    chk("level", 32'(level), 32'(lvl));
    chk("empty", 32'(empty), 32'(lvl == 0));
    chk("almostFull", 32'(almostFull), 32'(lvl >= AFULL));
    chk("ramWrEn", 32'(ramWrEn), 32'(m_push));
    if (m_push) begin
      chk("ramWrAddr", 32'(ramWrAddr), 32'(wr_cnt % DEPTH));
      chk("ramDin", 32'(ramDin), 32'(pdata));
    end
    chk("ramRdEn", 32'(ramRdEn), 32'(m_issue));
    if (m_issue) chk("ramRdAddr", 32'(ramRdAddr), 32'(rd_cnt % DEPTH));
    if (m_pop) begin
      if (sb.size() == 0) chk("pop_underflow", 32'(1), 32'(0));
      else chk("pop_order", 32'(bus.outData), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      if (m_pop) n_pops++;
      if (m_issue) begin
        hd = ram_q.pop_front();
        hv = 1'b1;
        rd_cnt++;
      end else if (m_pop) begin
        hv = 1'b0;
      end
      if (m_push) begin
        ram_q.push_back(pdata);
        sb.push_back(pdata);
        wr_cnt++;
      end
    end
  endtask

  initial begin
    // Reset held with both handshakes requested.
    rst          = 1'b0;
    flush        = 1'b0;
    bus.inValid  = 1'b1;
    bus.inData   = 8'hEE;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    tick();
    tick();
    rst         = 1'b1;
    bus.inValid = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_inReady", 32'(bus.inReady), 32'(1));
    chk("rst_outValid", 32'(bus.outValid), 32'(0));

    // Single word with the consumer stalled.
    bus.outReady = 1'b0;
    bus.inData   = 8'hA5;
    bus.inValid  = 1'b1;
    tick();
    bus.inValid = 1'b0;
    tick();
    #1;
    chk("single_outValid", 32'(bus.outValid), 32'(1));
    chk("single_outData", 32'(bus.outData), 32'(8'hA5));
    repeat (5) tick();
    chk("single_hold", 32'(bus.outData), 32'(8'hA5));
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    #1;
    chk("single_drain_level", 32'(level), 32'(0));
    chk("single_drain_valid", 32'(bus.outValid), 32'(0));

    // Fill: nine words fit, the tenth stalls.
    for (int i = 1; i <= 10; i++) begin
      bus.inData  = DW'(i);
      bus.inValid = 1'b1;
      tick();
    end
    chk("fill_level", 32'(level), 32'(9));
    chk("fill_inReady", 32'(bus.inReady), 32'(0));
    chk("fill_afull", 32'(almostFull), 32'(1));
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    #1;
    chk("fill_reopen", 32'(bus.inReady), 32'(1));
    bus.outReady = 1'b1;
    repeat (12) tick();
    chk("fill_empty", 32'(empty), 32'(1));

    // Streaming across pointer wrap.
    n_pops = 0;
    for (int i = 0; i < 20; i++) begin
      bus.inData  = DW'(i);
      bus.inValid = 1'b1;
      tick();
    end
    bus.inValid = 1'b0;
    repeat (4) tick();
    chk("stream_pops", 32'(n_pops), 32'(20));
    chk("stream_empty", 32'(empty), 32'(1));

    // Random traffic with backpressure.
    repeat (300) begin
      bus.inValid  = 1'($urandom % 2);
      bus.inData   = DW'($urandom);
      bus.outReady = 1'($urandom % 2);
      tick();
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    repeat (12) tick();
    chk("rand_empty", 32'(empty), 32'(1));

    // Flush with five words held and a push in the flush cycle.
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.inData  = DW'(8'h50 + i);
      bus.inValid = 1'b1;
      tick();
    end
    chk("flush_pre_level", 32'(level), 32'(5));
    flush       = 1'b1;
    bus.inData  = 8'h77;
    tick();
    flush       = 1'b0;
    bus.inValid = 1'b0;
    #1;
    chk("flush_level", 32'(level), 32'(0));
    chk("flush_outValid", 32'(bus.outValid), 32'(0));
    bus.inData  = 8'h3C;
    bus.inValid = 1'b1;
    tick();
    bus.inValid = 1'b0;
    tick();
    #1;
    chk("flush_next_valid", 32'(bus.outValid), 32'(1));
    chk("flush_next_data", 32'(bus.outData), 32'(8'h3C));
    bus.outReady = 1'b1;
    tick();
    tick();
    chk("flush_final_empty", 32'(empty), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
